// File: rtl/lsu_mem_ctrl_if.sv
// Handshake bundles for the load/store unit: execute-side request/response
// channel and the data-RAM request/completion channel.
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if;
  logic        mem_valid;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  mem_ready, mem_rvalid, mem_rdata
  );
  modport slave (
    input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit in front of the data RAM: alignment checks, byte-lane
// generation, single outstanding memory access with timeout, extended load data.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  lsu_req_if.slave  i_req,
  lsu_mem_if.master o_mem
);

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned MW    = DW / 8;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] SZ_B      = 2'b00;
  localparam logic [1:0] SZ_H      = 2'b01;
  localparam logic [1:0] SZ_W      = 2'b10;
  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_req_ready;
  logic               r_mem_valid;
  logic               r_mem_wen;
  logic [AW-1:0]      r_mem_addr;
  logic [DW-1:0]      r_mem_wdata;
  logic [MW-1:0]      r_mem_wmask;
  logic               r_resp_valid;
  logic [DW-1:0]      r_resp_rdata;
  logic [1:0]         r_resp_err;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [1:0]         r_off;
  logic [1:0]         r_size;
  logic               r_uns;

  logic               w_accept;
  logic               w_illegal;
  logic [1:0]         w_off;
  logic [MW-1:0]      w_wmask;
  logic [DW-1:0]      w_wdata;
  logic [DW-1:0]      w_ld_shift;
  logic [DW-1:0]      w_ld_data;
  logic               w_resp_load;
  logic [DW-1:0]      w_resp_rdata;
  logic [1:0]         w_resp_err;

  assign w_accept = i_req.req_valid & r_req_ready;

  // Alignment check and lane generation from the incoming request
  always_comb begin
    w_off     = i_req.req_addr[1:0];
    w_wmask   = 4'b1111;
    w_wdata   = i_req.req_wdata;
    w_illegal = 1'b0;
    case (i_req.req_size)
      SZ_B: begin
        w_wmask = 4'b0001 << w_off;
        w_wdata = {4{i_req.req_wdata[7:0]}};
      end
      SZ_H: begin
        w_wmask   = 4'b0011 << w_off;
        w_wdata   = {2{i_req.req_wdata[15:0]}};
        w_illegal = w_off[0];
      end
      SZ_W:    w_illegal = |w_off;
      default: w_illegal = 1'b1;
    endcase
  end

  // Lane-shift and extend the returned word; stores return zero
  always_comb begin
    w_ld_shift = o_mem.mem_rdata >> {r_off, 3'b000};
    w_ld_data  = w_ld_shift;
    case (r_size)
      SZ_B: w_ld_data = r_uns ? {24'd0, w_ld_shift[7:0]}
                              : {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
      SZ_H: w_ld_data = r_uns ? {16'd0, w_ld_shift[15:0]}
                              : {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
      default: ;
    endcase
    if (r_mem_wen) w_ld_data = '0;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_resp_load  = 1'b0;
    w_resp_rdata = '0;
    w_resp_err   = ERR_OK;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_illegal) begin
            w_state_nxt = S_RESP;
            w_resp_load = 1'b1;
            w_resp_err  = ERR_ALIGN;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (o_mem.mem_ready) begin
          w_cnt_nxt = '0;
          if (o_mem.mem_rvalid) begin
            w_state_nxt  = S_RESP;
            w_resp_load  = 1'b1;
            w_resp_rdata = w_ld_data;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (o_mem.mem_rvalid) begin
          w_state_nxt  = S_RESP;
          w_resp_load  = 1'b1;
          w_resp_rdata = w_ld_data;
        end else if ((TIMEOUT > 0) && (r_cnt == CNT_W'(TIMEOUT - 1))) begin
          w_state_nxt = S_RESP;
          w_resp_load = 1'b1;
          w_resp_err  = ERR_TMO;
        end
      end
      S_RESP: begin
        if (i_req.resp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_mem_wen    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wmask  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= ERR_OK;
      r_cnt        <= '0;
      r_off        <= '0;
      r_size       <= '0;
      r_uns        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_mem_valid  <= (w_state_nxt == S_ISSUE);
      r_resp_valid <= (w_state_nxt == S_RESP);
      r_cnt        <= w_cnt_nxt;
      if (w_accept) begin
        r_mem_wen   <= i_req.req_wen;
        r_mem_addr  <= {i_req.req_addr[AW-1:2], 2'b00};
        r_mem_wdata <= w_wdata;
        r_mem_wmask <= w_wmask;
        r_off       <= w_off;
        r_size      <= i_req.req_size;
        r_uns       <= i_req.req_unsigned;
      end
      if (w_resp_load) begin
        r_resp_rdata <= w_resp_rdata;
        r_resp_err   <= w_resp_err;
      end
    end
  end

  assign i_req.req_ready  = r_req_ready;
  assign i_req.resp_valid = r_resp_valid;
  assign i_req.resp_rdata = r_resp_rdata;
  assign i_req.resp_err   = r_resp_err;
  assign o_mem.mem_valid  = r_mem_valid;
  assign o_mem.mem_wen    = r_mem_wen;
  assign o_mem.mem_addr   = r_mem_addr;
  assign o_mem.mem_wdata  = r_mem_wdata;
  assign o_mem.mem_wmask  = r_mem_wmask;

endmodule
